// File: rtl/multicycle_alu.sv
// multicycle_alu
//   Handshaked ALU. Single-cycle functions (codes 0-9, 14, 15) produce a
//   result on the cycle after acceptance. MUL/MULH/DIVU/REMU (codes 10-13)
//   run one shift-add or restoring-subtract step per cycle for WIDTH cycles.
//   The result, zero and overflow flags are registered and hold their values
//   until the next result is written.
// Ports
//   clk, reset_n                  : clock (rising edge), async active-low reset
//   in_valid/in_ready             : request handshake (ready only when idle)
//   in_a, in_b, in_func           : operands and function code
//   abort                         : drop any in-flight or pending result
//   out_valid/out_ready           : result handshake
//   out_result, out_zero, out_ovf : result and flags, qualified by out_valid
module multicycle_alu #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_func,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf
);

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_AND  = 4'd2;
  localparam logic [3:0] F_OR   = 4'd3;
  localparam logic [3:0] F_NOT  = 4'd4;
  localparam logic [3:0] F_NEG  = 4'd5;
  localparam logic [3:0] F_SHL  = 4'd6;
  localparam logic [3:0] F_SHR  = 4'd7;
  localparam logic [3:0] F_BSHL = 4'd8;
  localparam logic [3:0] F_PASS = 4'd9;
  localparam logic [3:0] F_MUL  = 4'd10;
  localparam logic [3:0] F_REMU = 4'd13;
  localparam logic [3:0] F_DIVU = 4'd12;
  localparam logic [3:0] F_SRA  = 4'd14;
  localparam logic [3:0] F_ADD2 = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // r_q holds operand A on acceptance; during iteration it becomes the low
  // product half (MUL) or the quotient (DIVU). r_acc is the high product half
  // or the partial remainder.
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_func;
  logic [CNT_W-1:0] r_cnt;
  logic             r_zero;
  logic             r_ovf;

  logic             w_is_multi;
  logic             w_last;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_simple_res;
  logic             w_simple_ovf;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH-1:0] w_acc_step;
  logic [WIDTH-1:0] w_q_step;
  logic [WIDTH-1:0] w_multi_res;
  logic             w_multi_ovf;

  assign w_is_multi = (in_func >= F_MUL) && (in_func <= F_REMU);
  assign w_last     = (r_cnt == CNT_W'(1));
  assign w_sum      = in_a + in_b;
  assign w_diff     = in_a - in_b;

  // Single-cycle functions work straight off the input operands so the
  // result can be registered on the accepting edge.
  always_comb begin
    w_simple_res = in_a;
    w_simple_ovf = 1'b0;
    case (in_func)
      F_ADD, F_ADD2: begin
        w_simple_res = w_sum;
        w_simple_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      F_SUB: begin
        w_simple_res = w_diff;
        w_simple_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                       (w_diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      F_AND:  w_simple_res = in_a & in_b;
      F_OR:   w_simple_res = in_a | in_b;
      F_NOT:  w_simple_res = ~in_a;
      F_NEG: begin
        w_simple_res = '0 - in_a;
        w_simple_ovf = (in_a == {1'b1, {(WIDTH-1){1'b0}}});
      end
      F_SHL:  w_simple_res = {in_a[WIDTH-2:0], 1'b0};
      F_SHR:  w_simple_res = {1'b0, in_a[WIDTH-1:1]};
      F_BSHL: w_simple_res = in_b << 8;
      F_PASS: w_simple_res = in_a;
      F_SRA:  w_simple_res = {in_a[WIDTH-1], in_a[WIDTH-1:1]};
      default: ;
    endcase
  end

  // One iteration step. Multiply shifts {acc,q} right after a conditional add
  // of B; divide shifts the next dividend bit into the remainder and keeps
  // the subtraction only when it does not go negative. With B=0 the divide
  // subtracts every step, giving quotient all-ones and remainder A.
  assign w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
  assign w_div_shift = {r_acc, r_q[WIDTH-1]};

  always_comb begin
    w_acc_step  = r_acc;
    w_q_step    = r_q;
    w_multi_ovf = 1'b0;
    if (r_func[2]) begin
      if (w_div_shift >= {1'b0, r_b}) begin
        w_acc_step = w_div_shift[WIDTH-1:0] - r_b;
        w_q_step   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_step = w_div_shift[WIDTH-1:0];
        w_q_step   = {r_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_acc_step = w_mul_sum[WIDTH:1];
      w_q_step   = {w_mul_sum[0], r_q[WIDTH-1:1]};
    end
    // Odd codes (MULH, REMU) take the upper/remainder half.
    w_multi_res = r_func[0] ? w_acc_step : w_q_step;
    case (r_func)
      F_MUL:          w_multi_ovf = (w_acc_step != '0);
      F_DIVU, F_REMU: w_multi_ovf = (r_b == '0);
      default:        w_multi_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid) w_state_next = w_is_multi ? S_BUSY : S_DONE;
        S_BUSY:  if (w_last) w_state_next = S_DONE;
        S_DONE:  if (out_ready) w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Abort suppresses every datapath update so no result is written and the
  // previously delivered outputs stay as they were.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_b      <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_func   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (!abort) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_b    <= in_b;
            r_q    <= in_a;
            r_func <= in_func;
            r_acc  <= '0;
            if (w_is_multi) begin
              r_cnt <= CNT_W'(WIDTH);
            end else begin
              r_result <= w_simple_res;
              r_zero   <= (w_simple_res == '0);
              r_ovf    <= w_simple_ovf;
            end
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_step;
          r_q   <= w_q_step;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_result <= w_multi_res;
            r_zero   <= (w_multi_res == '0);
            r_ovf    <= w_multi_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_result;
  assign out_zero   = r_zero;
  assign out_ovf    = r_ovf;

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; legal values are 4 to 64.
REQ-002 Parameter CNT_W, default 6, width of the iteration counter; it SHALL be at least clog2(WIDTH)+1.
REQ-003 Port clk, input, 1 bit: single clock, rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: operation request.
REQ-006 Port in_ready, output, 1 bit: block can accept an operation.
REQ-007 Port in_a, input, WIDTH bits: operand A.
REQ-008 Port in_b, input, WIDTH bits: operand B.
REQ-009 Port in_func, input, 4 bits: function code.
REQ-010 Port abort, input, 1 bit: kill any in-flight operation.
REQ-011 Port out_valid, output, 1 bit: result available.
REQ-012 Port out_ready, input, 1 bit: consumer takes the result.
REQ-013 Port out_result, output, WIDTH bits: result.
REQ-014 Port out_zero, output, 1 bit: out_result equals 0.
REQ-015 Port out_ovf, output, 1 bit: overflow flag.

Function
REQ-016 Function codes SHALL be decoded as follows:
- 0 A+B; 1 A-B; 2 A&B; 3 A|B; 4 ~A; 5 -A
- 6 A<<1; 7 A>>1 (logical); 8 B<<8 (bits shifted out are lost); 9 A
- 10 MUL (low WIDTH bits of unsigned A*B); 11 MULH (high WIDTH bits of unsigned A*B)
- 12 DIVU (quotient); 13 REMU (remainder); 14 A>>>1 (arithmetic); 15 A+B
REQ-017 Operand capture and FSM:
- states IDLE, BUSY, DONE; in_ready=1 only in IDLE
- an operation is accepted when in_valid && in_ready; in_a, in_b and in_func are registered on acceptance
REQ-018 Codes 0-9, 14 and 15: IDLE goes directly to DONE; out_valid=1 on the cycle after acceptance (latency 1).
REQ-019 Codes 10-13:
- IDLE to BUSY, counter loaded with WIDTH
- one shift-add or restoring-subtract step per cycle; counter decrements
- BUSY to DONE when the counter reaches 0
- out_valid rises exactly WIDTH+1 cycles after acceptance
REQ-020 In DONE:
- out_valid=1; out_result, out_zero and out_ovf are held stable while out_ready=0
- DONE to IDLE on out_valid && out_ready; next acceptance is possible no earlier than the following cycle
REQ-021 Division by zero SHALL NOT be special-cased in the FSM: full WIDTH-cycle latency, DIVU result all-ones, REMU result A, out_ovf=1.
REQ-022 out_ovf per function:
- 0 and 15: signed overflow of A+B
- 1: signed overflow of A-B
- 5: A equals the most negative value
- 10: high half of the product is nonzero
- 12/13: divisor zero
- all other codes: 0
REQ-023 out_zero SHALL be computed from the final registered out_result in every state.
REQ-024 abort=1 in any state SHALL force IDLE on the next edge with out_valid=0 and no result delivered; abort has priority over acceptance and over out_ready.
REQ-025 out_result, out_zero and out_ovf SHALL keep their last values outside DONE; they are qualified only by out_valid.

Reset
REQ-026 reset_n=0 SHALL immediately, without a clock edge, force state IDLE, counter 0 and all internal registers 0: out_valid=0, out_result=0, out_zero=0, out_ovf=0; in_ready is 1 once reset_n=1.
REQ-027 Reset asserted mid-operation SHALL discard that operation; no out_valid follows after release.

Verification (WIDTH=16)
REQ-028 ADD, A=0x7FFF, B=0x0001 -> next cycle out_valid=1, out_result=0x8000, out_ovf=1, out_zero=0.
REQ-029 MUL 0x0123*0x0010 -> out_result=0x1230, out_ovf=0, out_valid exactly 17 cycles after accept; MULH 0xFFFF*0xFFFF -> 0xFFFE; MUL 0xFFFF*0xFFFF -> 0x0001 with out_ovf=1.
REQ-030 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x1234/0 -> 0xFFFF with out_ovf=1; REMU 0x1234/0 -> 0x1234.
REQ-031 SUB 5-5 with out_ready held 0 for 5 cycles -> out_result=0x0000, out_zero=1, outputs stable and in_ready=0 throughout; IDLE the cycle after out_ready=1.
REQ-032 DIVU accepted, abort pulsed on BUSY cycle 5 -> in_ready=1 next cycle, out_valid never asserted; a following ADD 2+3 returns 0x0005.
REQ-033 reset_n pulsed low during a MUL -> all outputs 0 asynchronously; no out_valid after release.
